// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Brief    : EX-stage bypass selects, load-use bubble and MULT/DIV HI/LO
//            interlock for a 5-stage MIPS pipeline. Optional macro
//            HAZ_PERF_CNT_EN adds a saturating stall-cycle counter (stall_cnt).
// Revision : 1.0
// ============================================================================
module fwd_hazard_unit #(
    parameter int AW      = 5,
    parameter int NSRC    = 2,
    parameter int MDU_LAT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC*AW-1:0]   ex_src_addr,
    input  logic [NSRC*AW-1:0]   id_src_addr,
    input  logic [NSRC-1:0]      id_src_valid,
    input  logic                 exmem_wr_en,
    input  logic [AW-1:0]        exmem_wr_addr,
    input  logic                 memwb_wr_en,
    input  logic [AW-1:0]        memwb_wr_addr,
    input  logic                 idex_mem_read,
    input  logic [AW-1:0]        idex_wr_addr,
    input  logic                 mdu_start,
    input  logic                 id_uses_hilo,
    output logic [2*NSRC-1:0]    fwd_sel,
    output logic                 stall_pc,
    output logic                 stall_ifid,
    output logic                 flush_idex,
    output logic                 mdu_busy,
    output logic                 mdu_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam int            CW     = $clog2(MDU_LAT + 1);
    localparam logic [CW-1:0] C_LOAD = CW'(MDU_LAT - 1);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic            r_err;
    logic [NSRC-1:0] w_lu_hit;
    logic            w_exmem_ok;
    logic            w_memwb_ok;
    logic            w_lu;
    logic            w_hl;
    logic            w_stall;

    assign w_exmem_ok = exmem_wr_en && (exmem_wr_addr != '0);
    assign w_memwb_ok = memwb_wr_en && (memwb_wr_addr != '0);

    for (genvar g = 0; g < NSRC; g++) begin : g_src
        logic [AW-1:0] w_ex_src;
        logic [AW-1:0] w_id_src;
        assign w_ex_src = ex_src_addr[g*AW +: AW];
        assign w_id_src = id_src_addr[g*AW +: AW];
        // EX/MEM holds the younger result, so it takes priority over MEM/WB.
        assign fwd_sel[2*g +: 2] =
            (w_exmem_ok && (exmem_wr_addr == w_ex_src)) ? 2'b10 :
            (w_memwb_ok && (memwb_wr_addr == w_ex_src)) ? 2'b01 : 2'b00;
        assign w_lu_hit[g] = id_src_valid[g] && (w_id_src == idex_wr_addr);
    end

    assign w_lu     = idex_mem_read && (idex_wr_addr != '0) && (|w_lu_hit);
    assign mdu_busy = (r_state == S_BUSY);
    assign mdu_err  = r_err;
    assign w_hl     = id_uses_hilo && (mdu_busy || mdu_start);

    // Gated by rst_n so the interlock releases the instant reset asserts.
    assign w_stall    = rst_n && (w_lu || w_hl);
    assign stall_pc   = w_stall;
    assign stall_ifid = w_stall;
    assign flush_idex = w_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (mdu_start) begin
                        r_state <= S_BUSY;
                        r_cnt   <= C_LOAD;
                    end
                end
                S_BUSY: begin
                    if (mdu_start) begin
                        r_err <= 1'b1;
                    end
                    if (r_cnt == '0) begin
                        r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// Self-checking bench for fwd_hazard_unit: vector table, MDU corner sequences
// and randomized traffic against a behavioural reference model.
module tb_fwd_hazard_unit;

    localparam int AW      = 5;
    localparam int NSRC    = 2;
    localparam int MDU_LAT = 4;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NSRC*AW-1:0]   ex_src_addr = '0;
    logic [NSRC*AW-1:0]   id_src_addr = '0;
    logic [NSRC-1:0]      id_src_valid = '0;
    logic                 exmem_wr_en = 1'b0;
    logic [AW-1:0]        exmem_wr_addr = '0;
    logic                 memwb_wr_en = 1'b0;
    logic [AW-1:0]        memwb_wr_addr = '0;
    logic                 idex_mem_read = 1'b0;
    logic [AW-1:0]        idex_wr_addr = '0;
    logic                 mdu_start = 1'b0;
    logic                 id_uses_hilo = 1'b0;
    logic [2*NSRC-1:0]    fwd_sel;
    logic                 stall_pc;
    logic                 stall_ifid;
    logic                 flush_idex;
    logic                 mdu_busy;
    logic                 mdu_err;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]          stall_cnt;
`endif

    fwd_hazard_unit #(.AW(AW), .NSRC(NSRC), .MDU_LAT(MDU_LAT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_src_addr   (ex_src_addr),
        .id_src_addr   (id_src_addr),
        .id_src_valid  (id_src_valid),
        .exmem_wr_en   (exmem_wr_en),
        .exmem_wr_addr (exmem_wr_addr),
        .memwb_wr_en   (memwb_wr_en),
        .memwb_wr_addr (memwb_wr_addr),
        .idex_mem_read (idex_mem_read),
        .idex_wr_addr  (idex_wr_addr),
        .mdu_start     (mdu_start),
        .id_uses_hilo  (id_uses_hilo),
        .fwd_sel       (fwd_sel),
        .stall_pc      (stall_pc),
        .stall_ifid    (stall_ifid),
        .flush_idex    (flush_idex),
        .mdu_busy      (mdu_busy),
        .mdu_err       (mdu_err)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state: remaining busy cycles, sticky error, stall tally.
    int m_left   = 0;
    bit m_err    = 1'b0;
    int m_stalls = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [2*NSRC-1:0] ref_fwd();
        logic [2*NSRC-1:0] r;
        r = '0;
        for (int i = 0; i < NSRC; i++) begin
            int src;
            src = int'(ex_src_addr[i*AW +: AW]);
            if (exmem_wr_en && exmem_wr_addr != 0 && int'(exmem_wr_addr) == src)
                r[2*i +: 2] = 2'b10;
            else if (memwb_wr_en && memwb_wr_addr != 0 && int'(memwb_wr_addr) == src)
                r[2*i +: 2] = 2'b01;
        end
        return r;
    endfunction

    function automatic bit ref_stall();
        bit lu;
        bit hl;
        lu = 1'b0;
        if (idex_mem_read && idex_wr_addr != 0)
            for (int i = 0; i < NSRC; i++)
                if (id_src_valid[i] && id_src_addr[i*AW +: AW] == idex_wr_addr) lu = 1'b1;
        hl = id_uses_hilo && ((m_left > 0) || mdu_start);
        return lu || hl;
    endfunction

    task automatic model_edge();
        if (ref_stall()) m_stalls++;
        if (m_left > 0) begin
            if (mdu_start) m_err = 1'b1;
            m_left--;
        end else if (mdu_start) begin
            m_left = MDU_LAT;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_left = 0; m_err = 1'b0; m_stalls = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_stall(input string name, input logic exp);
        chk({name, ".stall_pc"},   {31'd0, stall_pc},   {31'd0, exp});
        chk({name, ".stall_ifid"}, {31'd0, stall_ifid}, {31'd0, exp});
        chk({name, ".flush_idex"}, {31'd0, flush_idex}, {31'd0, exp});
    endtask

    typedef struct {
        logic [NSRC*AW-1:0] ex_src;
        logic [NSRC*AW-1:0] id_src;
        logic [NSRC-1:0]    id_valid;
        logic               exen;
        logic [AW-1:0]      exaddr;
        logic               wben;
        logic [AW-1:0]      wbaddr;
        logic               memrd;
        logic [AW-1:0]      idexaddr;
        logic [2*NSRC-1:0]  exp_fwd;
        logic               exp_stall;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{{5'd7, 5'd6}, {5'd0, 5'd0}, 2'b00, 1'b1, 5'd6, 1'b1, 5'd6, 1'b0, 5'd0, 4'b0010, 1'b0};
        tbl[1] = '{{5'd7, 5'd0}, {5'd0, 5'd0}, 2'b00, 1'b1, 5'd0, 1'b1, 5'd7, 1'b0, 5'd0, 4'b0100, 1'b0};
        tbl[2] = '{{5'd3, 5'd3}, {5'd0, 5'd0}, 2'b00, 1'b0, 5'd3, 1'b1, 5'd3, 1'b0, 5'd0, 4'b0101, 1'b0};
        tbl[3] = '{{5'd0, 5'd0}, {5'd0, 5'd7}, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 4'b0000, 1'b1};
        tbl[4] = '{{5'd0, 5'd0}, {5'd0, 5'd7}, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 4'b0000, 1'b0};
        tbl[5] = '{{5'd0, 5'd0}, {5'd0, 5'd0}, 2'b11, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 4'b0000, 1'b0};
        tbl[6] = '{{5'd9, 5'd9}, {5'd9, 5'd1}, 2'b10, 1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd9, 4'b1010, 1'b1};

        // Reset state.
        @(negedge clk);
        #1;
        chk("rst.busy", {31'd0, mdu_busy}, 32'd0);
        chk("rst.err",  {31'd0, mdu_err},  32'd0);
        chk("rst.fwd",  {28'd0, fwd_sel},  32'd0);
        chk_stall("rst", 1'b0);
        do_reset();

        // Combinational forwarding / load-use vectors.
        for (int v = 0; v < 7; v++) begin
            ex_src_addr   = tbl[v].ex_src;
            id_src_addr   = tbl[v].id_src;
            id_src_valid  = tbl[v].id_valid;
            exmem_wr_en   = tbl[v].exen;
            exmem_wr_addr = tbl[v].exaddr;
            memwb_wr_en   = tbl[v].wben;
            memwb_wr_addr = tbl[v].wbaddr;
            idex_mem_read = tbl[v].memrd;
            idex_wr_addr  = tbl[v].idexaddr;
            #1;
            chk($sformatf("vec%0d.fwd", v), {28'd0, fwd_sel}, {28'd0, tbl[v].exp_fwd});
            chk_stall($sformatf("vec%0d", v), tbl[v].exp_stall);
            next_cycle();
        end
        idex_mem_read = 1'b0;
        #1;
        chk_stall("lu_release", 1'b0);

        // MDU latency with a HI/LO reader held in ID.
        mdu_start = 1'b1; id_uses_hilo = 1'b1;
        #1;
        chk_stall("mdu.issue", 1'b1);
        chk("mdu.issue_busy", {31'd0, mdu_busy}, 32'd0);
        next_cycle();
        mdu_start = 1'b0;
        for (int k = 0; k < MDU_LAT; k++) begin
            #1;
            chk($sformatf("mdu.busy%0d", k), {31'd0, mdu_busy}, 32'd1);
            chk_stall($sformatf("mdu.cyc%0d", k), 1'b1);
            next_cycle();
        end
        #1;
        chk("mdu.done_busy", {31'd0, mdu_busy}, 32'd0);
        chk_stall("mdu.done", 1'b0);

        // Restart while busy: flagged, ignored.
        next_cycle();
        mdu_start = 1'b1;
        next_cycle();
        mdu_start = 1'b0;
        next_cycle();
        mdu_start = 1'b1;
        #1;
        chk("err.before", {31'd0, mdu_err}, 32'd0);
        next_cycle();
        mdu_start = 1'b0;
        #1;
        chk("err.set",   {31'd0, mdu_err},  32'd1);
        chk("err.busy3", {31'd0, mdu_busy}, 32'd1);
        next_cycle();
        #1;
        chk("err.busy4", {31'd0, mdu_busy}, 32'd1);
        next_cycle();
        #1;
        chk("err.end_busy", {31'd0, mdu_busy}, 32'd0);
        chk("err.sticky",   {31'd0, mdu_err},  32'd1);
        next_cycle();
        #1;
        chk("err.sticky2",  {31'd0, mdu_err},  32'd1);

        // Asynchronous reset in the middle of a busy window.
        mdu_start = 1'b1;
        next_cycle();
        mdu_start = 1'b0;
        #1;
        chk("arst.pre_busy", {31'd0, mdu_busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.busy", {31'd0, mdu_busy}, 32'd0);
        chk("arst.err",  {31'd0, mdu_err},  32'd0);
        chk_stall("arst", 1'b0);
`ifdef HAZ_PERF_CNT_EN
        chk("arst.stall_cnt", stall_cnt, 32'd0);
`endif
        id_uses_hilo = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_left = 0; m_err = 1'b0; m_stalls = 0;

        // Randomized traffic against the reference model.
        for (int it = 0; it < 400; it++) begin
            for (int i = 0; i < NSRC; i++) begin
                ex_src_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
                id_src_addr[i*AW +: AW] = AW'($urandom_range(0, 3));
            end
            id_src_valid  = NSRC'($urandom);
            exmem_wr_en   = 1'($urandom);
            exmem_wr_addr = AW'($urandom_range(0, 3));
            memwb_wr_en   = 1'($urandom);
            memwb_wr_addr = AW'($urandom_range(0, 3));
            idex_mem_read = 1'($urandom);
            idex_wr_addr  = AW'($urandom_range(0, 3));
            mdu_start     = ($urandom_range(0, 7) == 0);
            id_uses_hilo  = 1'($urandom);
            #1;
            chk("rnd.fwd",  {28'd0, fwd_sel},  {28'd0, ref_fwd()});
            chk_stall("rnd", ref_stall());
            chk("rnd.busy", {31'd0, mdu_busy}, {31'd0, (m_left > 0)});
            chk("rnd.err",  {31'd0, mdu_err},  {31'd0, m_err});
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end
`ifdef HAZ_PERF_CNT_EN
        #1;
        chk("rnd.stall_cnt", stall_cnt, 32'(m_stalls));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
